// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and defaults for the data-memory arbiter
package dmem_arb_pkg;
   localparam int DEF_AW = 16;
   localparam int DEF_DW = 16;
   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VGA} owner_e;
   function automatic owner_e read_owner(logic cpu_gnt, logic cpu_we, logic vga_gnt);
      return (cpu_gnt & ~cpu_we) ? OWN_CPU : vga_gnt ? OWN_VGA : OWN_NONE;
   endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with clear, flags when it sits at MAX
module sat_counter #(
   parameter int MAX = 8,
   parameter int W   = $clog2(MAX + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic sat
);
   logic [W-1:0] cnt_d, cnt_q;
   always_comb begin
      sat   = cnt_q == W'(MAX);
      cnt_d = clr ? '0 : (inc & ~sat) ? cnt_q + W'(1) : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port DataMem between CPU MEM stage and VGA reader
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW        = DEF_AW,
   parameter int DW        = DEF_DW,
   parameter int MAX_WAIT  = 8,
   parameter int VGA_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_stall,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          vga_req,
   input  logic [AW-1:0] vga_addr,
   output logic          vga_gnt,
   output logic          vga_rvalid,
   output logic [DW-1:0] vga_rdata,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_data,
   output logic          mem_wren,
   input  logic [DW-1:0] mem_q
);
   owner_e tag_d, tag_q;
   logic   wait_sat, vga_sat, cpu_win, wait_inc;
   sat_counter #(.MAX(MAX_WAIT)) u_wait (
      .clk(clk), .rst(rst), .inc(wait_inc), .clr(~wait_inc), .sat(wait_sat)
   );
   sat_counter #(.MAX(VGA_BURST)) u_run (
      .clk(clk), .rst(rst), .inc(vga_gnt), .clr(~vga_gnt), .sat(vga_sat)
   );
   // VGA owns contended cycles until the CPU has starved or VGA has hogged its burst
   always_comb begin
      cpu_win     = cpu_req & (~vga_req | wait_sat | vga_sat);
      cpu_gnt     = ~rst & cpu_win;
      vga_gnt     = ~rst & vga_req & ~cpu_win;
      cpu_stall   = cpu_req & ~cpu_gnt;
      wait_inc    = cpu_stall;
      mem_address = cpu_gnt ? cpu_addr : vga_gnt ? vga_addr : '0;
      mem_data    = cpu_gnt ? cpu_wdata : '0;
      mem_wren    = cpu_gnt & cpu_we;
      tag_d       = read_owner(cpu_gnt, cpu_we, vga_gnt);
      cpu_rvalid  = ~rst & (tag_q == OWN_CPU);
      vga_rvalid  = ~rst & (tag_q == OWN_VGA);
      cpu_rdata   = mem_q;
      vga_rdata   = mem_q;
   end
   always_ff @(posedge clk) begin
      if (rst) tag_q <= OWN_NONE;
      else tag_q <= tag_d;
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
   localparam int MAX_WAIT  = 8;
   localparam int VGA_BURST = 4;
   logic        clk = 0, rst = 1;
   logic        cpu_req = 0, cpu_we = 0, vga_req = 0;
   logic [15:0] cpu_addr = 0, cpu_wdata = 0, vga_addr = 0, mem_q, b_mem_q = 0;
   logic        cpu_gnt, cpu_stall, cpu_rvalid, vga_gnt, vga_rvalid, mem_wren;
   logic [15:0] cpu_rdata, vga_rdata, mem_address, mem_data;
   logic        b_cpu_gnt, b_cpu_stall, b_cpu_rvalid, b_vga_gnt, b_vga_rvalid, b_mem_wren;
   logic [15:0] b_cpu_rdata, b_vga_rdata, b_mem_address, b_mem_data;
   logic [15:0] mem  [0:255];
   logic [15:0] rmem [0:63];
   int          nchk = 0, nerr = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .VGA_BURST(VGA_BURST)) dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
      .cpu_rdata(cpu_rdata), .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
      .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata), .mem_address(mem_address),
      .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
   );
   dmem_arbiter #(.MAX_WAIT(8), .VGA_BURST(16)) dut_b (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_gnt(b_cpu_gnt), .cpu_stall(b_cpu_stall), .cpu_rvalid(b_cpu_rvalid),
      .cpu_rdata(b_cpu_rdata), .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(b_vga_gnt),
      .vga_rvalid(b_vga_rvalid), .vga_rdata(b_vga_rdata), .mem_address(b_mem_address),
      .mem_data(b_mem_data), .mem_wren(b_mem_wren), .mem_q(b_mem_q)
   );

   always @(posedge clk) begin
      if (mem_wren) mem[mem_address[7:0]] <= mem_data;
      mem_q <= mem[mem_address[7:0]];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      cpu_req = 0; vga_req = 0;
      repeat (n) tick();
   endtask

   task automatic test_reset();
      rst = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0005; vga_req = 1; vga_addr = 16'h0006;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         nchk++; if (cpu_gnt !== 1'b0) begin nerr++; $display("FAIL rst_cpu_gnt got=%b exp=0", cpu_gnt); end
         nchk++; if (vga_gnt !== 1'b0) begin nerr++; $display("FAIL rst_vga_gnt got=%b exp=0", vga_gnt); end
         nchk++; if (mem_wren !== 1'b0) begin nerr++; $display("FAIL rst_wren got=%b exp=0", mem_wren); end
         nchk++; if ({cpu_rvalid, vga_rvalid} !== 2'b00) begin nerr++; $display("FAIL rst_rvalid got=%b exp=00", {cpu_rvalid, vga_rvalid}); end
         tick();
      end
      rst = 0;
      @(negedge clk);
      nchk++; if (vga_gnt !== 1'b1) begin nerr++; $display("FAIL post_rst_vga_gnt got=%b exp=1", vga_gnt); end
      nchk++; if (cpu_stall !== 1'b1) begin nerr++; $display("FAIL post_rst_stall got=%b exp=1", cpu_stall); end
      tick();
      idle(2);
   endtask

   task automatic test_cpu_rw();
      cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
      @(negedge clk);
      nchk++; if ({cpu_gnt, mem_wren} !== 2'b11) begin nerr++; $display("FAIL wr_gnt_wren got=%b exp=11", {cpu_gnt, mem_wren}); end
      nchk++; if (mem_address !== 16'h0010 || mem_data !== 16'hBEEF) begin nerr++; $display("FAIL wr_addr_data got=%h/%h exp=0010/beef", mem_address, mem_data); end
      tick();
      cpu_we = 0; cpu_wdata = 16'h0;
      @(negedge clk);
      nchk++; if ({cpu_gnt, mem_wren, cpu_rvalid} !== 3'b100) begin nerr++; $display("FAIL rd_gnt got=%b exp=100", {cpu_gnt, mem_wren, cpu_rvalid}); end
      tick();
      cpu_req = 0;
      @(negedge clk);
      nchk++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hBEEF) begin nerr++; $display("FAIL rd_data got=%b/%h exp=1/beef", cpu_rvalid, cpu_rdata); end
      nchk++; if (vga_rvalid !== 1'b0) begin nerr++; $display("FAIL rd_vga_rvalid got=%b exp=0", vga_rvalid); end
      idle(2);
   endtask

   task automatic test_contention();
      int stalls = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0001; vga_req = 1; vga_addr = 16'h0002;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         stalls += int'(cpu_stall);
         nchk++; if ({cpu_gnt, vga_gnt} !== ((i % 5 == 4) ? 2'b10 : 2'b01)) begin nerr++; $display("FAIL contend_c%0d got=%b exp=%b", i, {cpu_gnt, vga_gnt}, (i % 5 == 4) ? 2'b10 : 2'b01); end
         tick();
      end
      nchk++; if (stalls !== 12) begin nerr++; $display("FAIL contend_stalls got=%0d exp=12", stalls); end
      idle(2);
   endtask

   task automatic test_burst16();
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0003; vga_req = 1; vga_addr = 16'h0004;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         nchk++; if ({b_cpu_gnt, b_vga_gnt} !== ((i == 8) ? 2'b10 : 2'b01)) begin nerr++; $display("FAIL burst16_c%0d got=%b exp=%b", i, {b_cpu_gnt, b_vga_gnt}, (i == 8) ? 2'b10 : 2'b01); end
         tick();
      end
      @(negedge clk);
      nchk++; if (dut_b.u_wait.cnt_q !== 4'd1) begin nerr++; $display("FAIL burst16_wait got=%0d exp=1", dut_b.u_wait.cnt_q); end
      idle(2);
   endtask

   task automatic test_back_to_back();
      cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h1111;
      tick();
      cpu_addr = 16'h0021; cpu_wdata = 16'h2222;
      tick();
      cpu_req = 0; cpu_we = 0; vga_req = 1; vga_addr = 16'h0020;
      @(negedge clk);
      nchk++; if (vga_gnt !== 1'b1) begin nerr++; $display("FAIL b2b_vga_gnt got=%b exp=1", vga_gnt); end
      tick();
      vga_req = 0; cpu_req = 1; cpu_addr = 16'h0021;
      @(negedge clk);
      nchk++; if (cpu_gnt !== 1'b1) begin nerr++; $display("FAIL b2b_cpu_gnt got=%b exp=1", cpu_gnt); end
      nchk++; if ({vga_rvalid, cpu_rvalid} !== 2'b10 || vga_rdata !== 16'h1111) begin nerr++; $display("FAIL b2b_vga_data got=%b/%h exp=10/1111", {vga_rvalid, cpu_rvalid}, vga_rdata); end
      tick();
      cpu_req = 0;
      @(negedge clk);
      nchk++; if ({vga_rvalid, cpu_rvalid} !== 2'b01 || cpu_rdata !== 16'h2222) begin nerr++; $display("FAIL b2b_cpu_data got=%b/%h exp=01/2222", {vga_rvalid, cpu_rvalid}, cpu_rdata); end
      idle(2);
   endtask

   task automatic test_reset_mid_read();
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
      @(negedge clk);
      nchk++; if (cpu_gnt !== 1'b1) begin nerr++; $display("FAIL mid_gnt got=%b exp=1", cpu_gnt); end
      tick();
      cpu_req = 0; rst = 1;
      @(negedge clk);
      nchk++; if (cpu_rvalid !== 1'b0) begin nerr++; $display("FAIL mid_rvalid got=%b exp=0", cpu_rvalid); end
      tick();
      rst = 0;
      @(negedge clk);
      nchk++; if (cpu_rvalid !== 1'b0) begin nerr++; $display("FAIL mid_rvalid_after got=%b exp=0", cpu_rvalid); end
      cpu_req = 1; vga_req = 1; vga_addr = 16'h0007;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         nchk++; if (cpu_stall !== 1'b1) begin nerr++; $display("FAIL drop_stall_c%0d got=%b exp=1", i, cpu_stall); end
         tick();
      end
      cpu_req = 0;
      tick();
      @(negedge clk);
      nchk++; if (dut.u_wait.cnt_q !== 4'd0) begin nerr++; $display("FAIL drop_wait got=%0d exp=0", dut.u_wait.cnt_q); end
      idle(2);
   endtask

   task automatic test_random();
      bit cp = 0, vp = 0, ec, ev;
      int ew = 0, er = 0, eo = 0;
      logic [15:0] ed = 0, ea;
      cpu_we = 1; cpu_req = 1;
      for (int a = 0; a < 64; a++) begin
         cpu_addr = 16'(a); cpu_wdata = 16'($urandom); rmem[a] = cpu_wdata;
         tick();
      end
      idle(2);
      for (int c = 0; c < 400; c++) begin
         if (cp) begin
            if ($urandom_range(9) == 0) cpu_req = 0;
         end else begin
            cpu_req = 1'($urandom_range(1)); cpu_we = 1'($urandom_range(1));
            cpu_addr = 16'($urandom_range(63)); cpu_wdata = 16'($urandom);
         end
         if (!vp) begin vga_req = 1'($urandom_range(1)); vga_addr = 16'($urandom_range(63)); end
         ec = cpu_req && (!vga_req || ew >= MAX_WAIT || er >= VGA_BURST);
         ev = vga_req && !ec;
         ea = ec ? cpu_addr : ev ? vga_addr : 16'h0;
         @(negedge clk);
         nchk++; if ({cpu_gnt, vga_gnt} !== {ec, ev}) begin nerr++; $display("FAIL rnd_gnt c%0d got=%b exp=%b", c, {cpu_gnt, vga_gnt}, {ec, ev}); end
         nchk++; if (mem_wren !== (ec && cpu_we) || mem_address !== ea) begin nerr++; $display("FAIL rnd_mem c%0d got=%b/%h exp=%b/%h", c, mem_wren, mem_address, ec && cpu_we, ea); end
         nchk++; if ({cpu_rvalid, vga_rvalid} !== {eo == 1, eo == 2}) begin nerr++; $display("FAIL rnd_rvalid c%0d got=%b exp=%b", c, {cpu_rvalid, vga_rvalid}, {eo == 1, eo == 2}); end
         if (eo == 1) begin nchk++; if (cpu_rdata !== ed) begin nerr++; $display("FAIL rnd_cpu_rdata c%0d got=%h exp=%h", c, cpu_rdata, ed); end end
         if (eo == 2) begin nchk++; if (vga_rdata !== ed) begin nerr++; $display("FAIL rnd_vga_rdata c%0d got=%h exp=%h", c, vga_rdata, ed); end end
         eo = (ec && !cpu_we) ? 1 : ev ? 2 : 0;
         ed = rmem[ea[5:0]];
         if (ec && cpu_we) rmem[cpu_addr[5:0]] = cpu_wdata;
         ew = (cpu_req && !ec) ? ((ew + 1 > MAX_WAIT) ? MAX_WAIT : ew + 1) : 0;
         er = ev ? ((er + 1 > VGA_BURST) ? VGA_BURST : er + 1) : 0;
         cp = cpu_req && !ec;
         vp = vga_req && !ev;
         tick();
      end
      idle(2);
   endtask

   initial begin
      test_reset();
      test_cpu_rw();
      test_contention();
      test_burst16();
      test_back_to_back();
      test_reset_mid_read();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single-port synchronous data memory between the CPU MEM stage and the VGA framebuffer reader.
- Sits between the pipeline/VGA scan logic and DataMem, and drives DataMem address/data/wren.
- Stalls the CPU pipeline while the CPU is denied access.
- Tags every read so the data returning one cycle later reaches the requester that issued it.

Parameters:
AW, 16, address width (memory and requesters)
DW, 16, data width
MAX_WAIT, 8, consecutive denied CPU cycles after which the CPU wins a contended cycle
VGA_BURST, 4, maximum consecutive VGA grants while the CPU is also requesting

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; hold with addr/we/wdata stable until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  CPU access accepted this cycle
cpu_stall  out  1  freeze pipeline (cpu_req & ~cpu_gnt)
cpu_rvalid  out  1  cpu_rdata valid (one cycle after a granted CPU read)
cpu_rdata  out  DW  read data for the CPU
vga_req  in  1  VGA read request; hold with addr stable until vga_gnt
vga_addr  in  AW  VGA address
vga_gnt  out  1  VGA access accepted this cycle
vga_rvalid  out  1  vga_rdata valid (one cycle after a granted VGA read)
vga_rdata  out  DW  read data for VGA
mem_address  out  AW  to DataMem address
mem_data  out  DW  to DataMem write data
mem_wren  out  1  to DataMem write enable
mem_q  in  DW  from DataMem; valid the cycle after the address is presented

Behaviour:
Grant decision (combinational, from inputs and registered state):
- Only one requester: it is granted.
- Both requesting: VGA wins unless wait_cnt == MAX_WAIT or vga_run == VGA_BURST; in either case the CPU wins.
- While rst = 1: both gnt outputs are forced to 0.
Memory drive (combinational):
- Granted requester's address drives mem_address; the CPU's wdata drives mem_data.
- mem_wren = cpu_gnt & cpu_we.
- No grant: mem_address, mem_data and mem_wren are 0.
- VGA accesses are always reads.
Read tag register (owner: NONE/CPU/VGA):
- Loads CPU on a granted CPU read, VGA on a granted VGA read, otherwise NONE.
- cpu_rvalid = (tag == CPU); vga_rvalid = (tag == VGA).
- cpu_rdata = vga_rdata = mem_q; rvalid is the only qualifier.
- Latency is 1 cycle from grant to rvalid. Back-to-back grants pipeline fully, so reads from different requesters never cross.
- A CPU write produces no rvalid.
wait_cnt (0..MAX_WAIT):
- Increments when cpu_req & ~cpu_gnt, saturating at MAX_WAIT.
- Clears on cpu_gnt or ~cpu_req.
- Dropping a request before it is granted is legal and clears the count.
vga_run (0..VGA_BURST):
- Increments on vga_gnt, saturating.
- Clears in any cycle without vga_gnt.
Reset:
- wait_cnt = 0, vga_run = 0, tag = NONE.
- Reset mid-read: the pending rvalid is suppressed (rvalid = 0 the cycle after rst).
- First cycle after rst deasserts: arbitration is fresh, so VGA wins contention.
Throughput: one access per cycle, and the memory is never idle while any request is pending.

Decomposition:
- Package dmem_arb_pkg holds: typedef enum logic [1:0] owner_e {OWN_NONE, OWN_CPU, OWN_VGA}; default AW/DW constants.
- One sub-module, sat_counter (parameterised width/max, with inc, clr and sat flag), instantiated for wait_cnt and vga_run.
- Everything else is in dmem_arbiter.

Test Plan:
1. Reset: rst = 1 for 2 cycles with both requests high -> gnt = 0 for both, mem_wren = 0, both rvalid = 0. Cycle after release -> vga_gnt = 1, cpu_stall = 1.
2. CPU alone writes 0xBEEF to 0x0010, then reads 0x0010 -> write cycle: cpu_gnt = 1, mem_wren = 1, mem_address = 0x0010. Read: cpu_rvalid = 1 the next cycle with cpu_rdata = 0xBEEF, and vga_rvalid stays 0.
3. Both requesting continuously (defaults) -> grant pattern repeats VGA, VGA, VGA, VGA, CPU; cpu_stall is high 4 of every 5 cycles.
4. VGA_BURST = 16, both requesting continuously -> CPU granted on the 9th cycle (after 8 denials), then wait_cnt = 0.
5. VGA read 0x0020 (contents 0x1111) in cycle n, CPU read 0x0021 (contents 0x2222) in cycle n+1 -> vga_rvalid with 0x1111 at n+1, cpu_rvalid with 0x2222 at n+2, no cross-delivery.
6. CPU read granted at cycle n, rst = 1 at n+1 -> cpu_rvalid = 0 at n+1. Separately, CPU denied 3 cycles then cpu_req dropped -> wait_cnt = 0.
